// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder slice: frame geometry,
// sample layout, bit-reversal helper and the read-side state encoding.
package fft_pkg;

  localparam int FFT_LOG2N = 4;
  localparam int FFT_N     = 1 << FFT_LOG2N;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } fft_sample_t;

  typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

  // Reverses the low log2n bits of idx; bits above log2n come back as zero.
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx,
                                                  input int log2n);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < FFT_LOG2N; i++) begin
      if (i < log2n) r[i] = idx[log2n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two N-entry sample banks sharing one write port and one combinational
// read port; the bank bit is the top address bit.
module fft_pingpong_ram #(
  parameter int LOG2N  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [LOG2N-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [LOG2N-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 << LOG2N;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_out_reorder.sv
// Collects bit-reversed FFT output into a ping-pong buffer and streams each
// completed frame in natural frequency order to a valid/ready consumer.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int LOG2N  = FFT_LOG2N,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_push,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [7:0]        frame_cnt,
  output logic              ovf_err
);

  localparam int N = 1 << LOG2N;

  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  logic [LOG2N-1:0]  wr_cnt;
  logic [LOG2N-1:0]  wr_addr;
  logic [LOG2N-1:0]  rd_cnt;
  logic [LOG2N-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              push_ok;
  logic              wr_done;
  logic              rd_load;
  logic              rd_done;
  rd_state_t         state;
  rd_state_t         state_next;

  // The FFT is held off only while the bank it would write still holds an
  // undrained frame; this is purely a register decode.
  assign in_stall = full[wr_bank];
  assign push_ok  = in_push && !in_stall;
  assign wr_done  = push_ok && (wr_cnt == LOG2N'(N-1));
  assign wr_addr  = bitrev(wr_cnt, LOG2N);

  fft_pingpong_ram #(
    .LOG2N  (LOG2N),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_cnt <= wr_cnt + LOG2N'(1);
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (in_push && in_stall) ovf_err <= 1'b1;
    end
  end

  // Set and clear always hit different banks: the writer only fills an empty
  // bank while the reader only drains a full one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= '0;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  // Handshake: a sample transfers on a rising clk edge with out_valid &&
  // out_ready; while out_valid && !out_ready, out_data/out_last are held, and
  // out_valid drops only after the out_last sample has transferred.
  always_comb begin
    state_next = state;
    rd_load    = 1'b0;
    rd_done    = 1'b0;
    rd_addr    = rd_cnt;
    case (state)
      R_IDLE: begin
        rd_addr = '0;
        if (full[rd_bank]) begin
          rd_load    = 1'b1;
          state_next = R_STREAM;
        end
      end
      R_STREAM: begin
        if (out_ready) begin
          if (out_last) begin
            rd_done    = 1'b1;
            state_next = R_IDLE;
          end else begin
            rd_load = 1'b1;
          end
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= R_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      frame_cnt <= '0;
    end else if (rd_load) begin
      out_data  <= rd_data;
      out_valid <= 1'b1;
      out_last  <= (rd_addr == LOG2N'(N-1));
      rd_cnt    <= rd_addr + LOG2N'(1);
    end else if (rd_done) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      rd_bank   <= ~rd_bank;
      frame_cnt <= frame_cnt + 8'd1;
      rd_cnt    <= '0;
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: a frame-level reference model predicts the
// natural-order output stream, stall behaviour and counters.
module tb_fft_out_reorder;

  localparam int N = 16;
  localparam int W = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_push;
  logic [31:0] in_data;
  logic        in_stall;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic [7:0]  frame_cnt;
  logic        ovf_err;

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  got_q[$];
  logic [31:0]   cur_q[$];
  int            held;
  logic          model_ovf;
  logic [7:0]    model_frames;

  always #5 clk = ~clk;

  fft_out_reorder dut (
    .clk       (clk),
    .reset     (reset),
    .in_push   (in_push),
    .in_data   (in_data),
    .in_stall  (in_stall),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt),
    .ovf_err   (ovf_err)
  );

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_q.push_back({out_last, out_data});
      if (out_last) held--;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    got_q.delete();
    cur_q.delete();
    held         = 0;
    model_ovf    = 1'b0;
    model_frames = 8'd0;
  endtask

  // Called at posedge+1; drives one push for a single cycle.
  task automatic push_sample(input logic [31:0] d);
    logic pred;
    pred    = (held == 2);
    in_push = 1'b1;
    in_data = d;
    checks++;
    if (in_stall !== pred) begin
      errors++;
      $display("FAIL stall_pred: in_stall=%0b expected %0b", in_stall, pred);
    end
    if (!pred) begin
      cur_q.push_back(d);
      if (cur_q.size() == N) begin
        for (int k = 0; k < N; k++) exp_q.push_back({k == N-1, cur_q[rev4(k)]});
        cur_q.delete();
        held++;
        model_frames++;
      end
    end else begin
      model_ovf = 1'b1;
    end
    @(posedge clk); #1;
    in_push = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (got_q.size() >= exp_q.size()) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, out_data, out_last, frame_cnt, ovf_err, in_stall} !== '0) begin
      errors++;
      $display("FAIL reset_hold: v=%0b d=%h l=%0b fc=%0d ovf=%0b st=%0b expected all 0",
               out_valid, out_data, out_last, frame_cnt, ovf_err, in_stall);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_data, out_last, frame_cnt, ovf_err, in_stall} !== '0) begin
      errors++;
      $display("FAIL reset_release: v=%0b d=%h l=%0b fc=%0d ovf=%0b st=%0b expected all 0",
               out_valid, out_data, out_last, frame_cnt, ovf_err, in_stall);
    end
    model_reset();
  endtask

  task automatic test_single_frame();
    bit to;
    logic [W-1:0] e, g;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) push_sample(32'(i));
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: out_valid=%0b expected 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: out_valid=%0b expected 1", out_valid);
    end
    wait_drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL single_drain: got %0d samples expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL single_sample: got %h expected %h", g, e);
      end
    end
    checks++;
    if (frame_cnt !== model_frames || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL single_counters: fc=%0d ovf=%0b expected fc=%0d ovf=0", frame_cnt, ovf_err, model_frames);
    end
  endtask

  task automatic test_back_pressure();
    bit to;
    int phase, gap;
    logic [W-1:0] e, g;
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++)
        push_sample({16'($urandom_range(0, 65535)), 8'h00, 4'(f), 4'(i)});
    checks++;
    if (ovf_err !== model_ovf || in_stall !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: ovf=%0b st=%0b expected ovf=%0b st=1", ovf_err, in_stall, model_ovf);
    end
    out_ready = 1'b1;
    phase = 0;
    gap   = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (phase == 1) begin
        if (!out_valid) gap++;
        else phase = 2;
      end
      if (phase == 0 && out_valid && out_last) phase = 1;
      if (phase == 2) break;
    end
    checks++;
    if (phase != 2 || gap != 1) begin
      errors++;
      $display("FAIL bp_idle_gap: gap=%0d phase=%0d expected gap=1 phase=2", gap, phase);
    end
    wait_drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bp_drain: got %0d samples expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL bp_sample: got %h expected %h", g, e);
      end
    end
    checks++;
    if (frame_cnt !== model_frames || ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL bp_counters: fc=%0d ovf=%0b expected fc=%0d ovf=1", frame_cnt, ovf_err, model_frames);
    end
  endtask

  task automatic test_ready_toggle();
    bit to;
    logic prev_hold;
    logic [31:0] prev_d;
    logic prev_l;
    logic [W-1:0] e, g;
    prev_hold = 1'b0;
    prev_d    = '0;
    prev_l    = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * N; i++) push_sample($urandom);
      end
      begin
        for (int c = 0; c < 90; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (prev_hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
              errors++;
              $display("FAIL toggle_hold: v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                       out_valid, out_data, out_last, prev_d, prev_l);
            end
          end
          prev_hold = out_valid && !out_ready;
          prev_d    = out_data;
          prev_l    = out_last;
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL toggle_drain: got %0d samples expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL toggle_sample: got %h expected %h", g, e);
      end
    end
    checks++;
    if (frame_cnt !== model_frames) begin
      errors++;
      $display("FAIL toggle_frames: fc=%0d expected %0d", frame_cnt, model_frames);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int stall_seen;
    logic [W-1:0] e, g;
    out_ready  = 1'b1;
    stall_seen = 0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin
        if (in_stall) stall_seen++;
        push_sample($urandom);
      end
      repeat (2) begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (stall_seen != 0) begin
      errors++;
      $display("FAIL b2b_stall: in_stall seen %0d times expected 0", stall_seen);
    end
    wait_drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL b2b_drain: got %0d samples expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_sample: got %h expected %h", g, e);
      end
    end
    checks++;
    if (frame_cnt !== model_frames) begin
      errors++;
      $display("FAIL b2b_frames: fc=%0d expected %0d", frame_cnt, model_frames);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [W-1:0] e, g;
    out_ready = 1'b1;
    for (int i = 0; i < N + 7; i++) push_sample($urandom);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_last, frame_cnt, ovf_err, in_stall} !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: v=%0b d=%h l=%0b fc=%0d ovf=%0b st=%0b expected all 0",
               out_valid, out_data, out_last, frame_cnt, ovf_err, in_stall);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) push_sample($urandom);
    wait_drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL mid_drain: got %0d samples expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL mid_sample: got %h expected %h", g, e);
      end
    end
    checks++;
    if (frame_cnt !== 8'd1 || ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_counters: fc=%0d ovf=%0b expected fc=1 ovf=0", frame_cnt, ovf_err);
    end
  endtask

  task automatic test_freed_bank();
    bit to, found;
    logic [W-1:0] e, g;
    out_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++) push_sample($urandom);
    checks++;
    if (in_stall !== 1'b1) begin
      errors++;
      $display("FAIL freed_full: in_stall=%0b expected 1", in_stall);
    end
    out_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL freed_last: out_last handshake seen=%0b expected 1", found);
    end
    @(posedge clk); #1;
    checks++;
    if (in_stall !== 1'b0) begin
      errors++;
      $display("FAIL freed_stall_drop: in_stall=%0b expected 0", in_stall);
    end
    for (int i = 0; i < N; i++) push_sample($urandom);
    wait_drain(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL freed_drain: got %0d samples expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL freed_sample: got %h expected %h", g, e);
      end
    end
    checks++;
    if (frame_cnt !== model_frames) begin
      errors++;
      $display("FAIL freed_frames: fc=%0d expected %0d", frame_cnt, model_frames);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_push   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_ready_toggle();
    test_back_to_back();
    test_reset_mid();
    test_freed_bank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
